// File: rtl/dotprod_vec_feeder_if.sv
// Bundle of all non-clock/reset signals of dotprod_vec_feeder.
//   cfg_*   : job configuration handshake (vector length N)
//   s_*     : input word stream (N words for A, then N words for B)
//   a_*/b_* : dotprod-side memory ports of the A and B banks
//   dp_*    : control/status wires to and from the dotprod core
//   res_*   : captured result handshake, err flags a clamped or timed-out job
// slave  : the feeder itself
// master : the environment (producer, dotprod core, result consumer)
interface dotprod_vec_feeder_if #(
    parameter int unsigned DATA_W = 32
);
    logic [31:0]       cfg_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              a_ce0;
    logic              a_we0;
    logic [31:0]       a_address0;
    logic [DATA_W-1:0] a_ad0;
    logic [DATA_W-1:0] a_q0;
    logic              b_ce0;
    logic              b_we0;
    logic [31:0]       b_address0;
    logic [DATA_W-1:0] b_ad0;
    logic [DATA_W-1:0] b_q0;
    logic              dp_rst_n;
    logic              dp_start;
    logic [31:0]       dp_n;
    logic              dp_done;
    logic [31:0]       dp_return;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              res_ready;
    logic              err;

    modport slave (
        input  cfg_n, cfg_valid, s_data, s_valid,
        input  a_ce0, a_we0, a_address0, a_ad0,
        input  b_ce0, b_we0, b_address0, b_ad0,
        input  dp_done, dp_return, res_ready,
        output cfg_ready, s_ready, a_q0, b_q0,
        output dp_rst_n, dp_start, dp_n, res_data, res_valid, err
    );

    modport master (
        output cfg_n, cfg_valid, s_data, s_valid,
        output a_ce0, a_we0, a_address0, a_ad0,
        output b_ce0, b_we0, b_address0, b_ad0,
        output dp_done, dp_return, res_ready,
        input  cfg_ready, s_ready, a_q0, b_q0,
        input  dp_rst_n, dp_start, dp_n, res_data, res_valid, err
    );
endinterface

// File: rtl/dotprod_vec_feeder.sv
// Upstream stage of the dotprod accelerator. Accepts a vector length N, streams N words into
// bank A and N words into bank B, pulses the dotprod reset for one cycle, holds ap_start
// until ap_done (or a timeout) and presents the captured result on a valid/ready handshake.
// Ports:
//   ap_clk   : clock
//   ap_rst_n : asynchronous active-low reset
//   bus_io   : cfg / stream / bank memory ports / dotprod control / result (see interface)
module dotprod_vec_feeder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    dotprod_vec_feeder_if.slave  bus_io
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StLoadA, StLoadB, StClear, StRun, StResult
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [31:0]         n_eff_q, n_eff_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                s_ready_q, s_ready_d;
    logic                dp_start_q, dp_start_d;
    logic                clr_q, clr_d;
    logic                res_valid_q, res_valid_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   a_q_q, a_q_d;
    logic [DATA_W-1:0]   b_q_q, b_q_d;

    logic [DATA_W-1:0]   ram_a [DEPTH];
    logic [DATA_W-1:0]   ram_b [DEPTH];

    logic                cfg_fire;
    logic                s_fire;
    logic                last_word;
    logic                a_in_range;
    logic                b_in_range;
    logic [ADDR_W-1:0]   a_idx;
    logic [ADDR_W-1:0]   b_idx;

    assign cfg_fire   = bus_io.cfg_valid & cfg_ready_q;
    assign s_fire     = bus_io.s_valid & s_ready_q;
    assign last_word  = (32'(idx_q) == n_eff_q - 32'd1);
    assign a_in_range = (bus_io.a_address0 < 32'(DEPTH));
    assign b_in_range = (bus_io.b_address0 < 32'(DEPTH));
    assign a_idx      = bus_io.a_address0[ADDR_W-1:0];
    assign b_idx      = bus_io.b_address0[ADDR_W-1:0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_eff_d     = n_eff_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (cfg_fire) begin
                    if (bus_io.cfg_n > 32'(DEPTH)) begin
                        n_eff_d = 32'(DEPTH);
                        err_d   = 1'b1;
                    end else begin
                        n_eff_d = bus_io.cfg_n;
                        err_d   = 1'b0;
                    end
                    idx_d   = '0;
                    // An empty job still runs dotprod once (it returns 0).
                    state_d = (bus_io.cfg_n == 32'd0) ? StClear : StLoadA;
                end
            end
            StLoadA: begin
                if (s_fire) begin
                    if (last_word) begin
                        idx_d   = '0;
                        state_d = StLoadB;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StLoadB: begin
                if (s_fire) begin
                    if (last_word) begin
                        idx_d   = '0;
                        state_d = StClear;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StClear: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                // ap_done in the first RUN cycle may be left over from before the clear.
                if (cnt_q != '0 && bus_io.dp_done) begin
                    res_data_d  = DATA_W'(bus_io.dp_return);
                    res_valid_d = 1'b1;
                    state_d     = StResult;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    res_data_d  = '0;
                    res_valid_d = 1'b1;
                    err_d       = 1'b1;
                    state_d     = StResult;
                end
            end
            StResult: begin
                if (bus_io.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs registered from the next state so they line up with state_q.
        cfg_ready_d = (state_d == StIdle);
        s_ready_d   = (state_d == StLoadA) || (state_d == StLoadB);
        dp_start_d  = (state_d == StRun);
        clr_d       = (state_d == StClear);
    end

    always_comb begin
        a_q_d = a_q_q;
        b_q_d = b_q_q;
        if (bus_io.a_ce0) begin
            a_q_d = a_in_range ? ram_a[a_idx] : '0;
        end
        if (bus_io.b_ce0) begin
            b_q_d = b_in_range ? ram_b[b_idx] : '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            n_eff_q     <= '0;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b1;
            s_ready_q   <= 1'b0;
            dp_start_q  <= 1'b0;
            clr_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            a_q_q       <= '0;
            b_q_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_eff_q     <= n_eff_d;
            cnt_q       <= cnt_d;
            cfg_ready_q <= cfg_ready_d;
            s_ready_q   <= s_ready_d;
            dp_start_q  <= dp_start_d;
            clr_q       <= clr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
            a_q_q       <= a_q_d;
            b_q_q       <= b_q_d;
        end
    end

    // Bank storage: no reset, contents survive ap_rst_n. Stream loads and consumer writes
    // are confined to disjoint states, so they never collide.
    always_ff @(posedge ap_clk) begin
        if (state_q == StLoadA && s_fire) begin
            ram_a[idx_q[ADDR_W-1:0]] <= bus_io.s_data;
        end else if (state_q == StRun && bus_io.a_ce0 && bus_io.a_we0 && a_in_range) begin
            ram_a[a_idx] <= bus_io.a_ad0;
        end
        if (state_q == StLoadB && s_fire) begin
            ram_b[idx_q[ADDR_W-1:0]] <= bus_io.s_data;
        end else if (state_q == StRun && bus_io.b_ce0 && bus_io.b_we0 && b_in_range) begin
            ram_b[b_idx] <= bus_io.b_ad0;
        end
    end

    assign bus_io.cfg_ready = cfg_ready_q;
    assign bus_io.s_ready   = s_ready_q;
    assign bus_io.a_q0      = a_q_q;
    assign bus_io.b_q0      = b_q_q;
    assign bus_io.dp_rst_n  = ap_rst_n & ~clr_q;
    assign bus_io.dp_start  = dp_start_q;
    assign bus_io.dp_n      = n_eff_q;
    assign bus_io.res_data  = res_data_q;
    assign bus_io.res_valid = res_valid_q;
    assign bus_io.err       = err_q;

endmodule
